// File: rtl/mul_add_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
package mul_add_pkg;

    localparam int unsigned MUL_ADD_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_add_ctrl.sv
// Control FSM for mul_add_seq: sequences load, repeated add/decrement and result store.
module mul_add_ctrl
    import mul_add_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cnt_zero,
    output logic load,
    output logic add,
    output logic dec,
    output logic store,
    output logic busy,
    output logic done
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // busy/done decode only the state register, so no input reaches them combinationally
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        add     = 1'b0;
        dec     = 1'b0;
        store   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    store   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    add = 1'b1;
                    dec = 1'b1;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mul_add_seq.sv
// Sequential multiplier by repeated addition; smaller magnitude drives the loop count.
// Define MUL_ADD_SIGNED_EN for two's-complement operands and product.
module mul_add_seq
    import mul_add_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_ADD_WIDTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WIDTH-1:0]               a_in,
    input  logic [WIDTH-1:0]               b_in,
    output logic                           busy,
    output logic                           done,
    output logic [prod_width(WIDTH)-1:0]   product
);

    localparam int unsigned PW = prod_width(WIDTH);
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] addend_q, addend_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             load, add, dec, store, cnt_zero;
`ifdef MUL_ADD_SIGNED_EN
    logic             sign_q, sign_d;
`endif

    assign cnt_zero = (cnt_q == '0);

    mul_add_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cnt_zero (cnt_zero),
        .load     (load),
        .add      (add),
        .dec      (dec),
        .store    (store),
        .busy     (busy),
        .done     (done)
    );

    always_comb begin
`ifdef MUL_ADD_SIGNED_EN
        // the most negative value wraps to 2^(WIDTH-1), which fits the unsigned register
        mag_a  = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
        mag_b  = b_in[WIDTH-1] ? ('0 - b_in) : b_in;
        sign_d = sign_q;
`else
        mag_a  = a_in;
        mag_b  = b_in;
`endif
        acc_d     = acc_q;
        addend_d  = addend_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        if (load) begin
            acc_d     = '0;
            product_d = '0;
`ifdef MUL_ADD_SIGNED_EN
            sign_d    = a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
            if (mag_a >= mag_b) begin
                addend_d = mag_a;
                cnt_d    = mag_b;
            end else begin
                addend_d = mag_b;
                cnt_d    = mag_a;
            end
        end
        if (add) begin
            acc_d = acc_q + {{WIDTH{1'b0}}, addend_q};
        end
        if (dec) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (store) begin
`ifdef MUL_ADD_SIGNED_EN
            product_d = sign_q ? ('0 - acc_q) : acc_q;
`else
            product_d = acc_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            addend_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_ADD_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            addend_q  <= addend_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_ADD_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq (WIDTH=16); signed cases run when MUL_ADD_SIGNED_EN is defined.
module tb_mul_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    mul_add_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned t = 0;
    int unsigned t0 = 0;

    function automatic int unsigned model_n(input logic [15:0] a, input logic [15:0] b);
        int unsigned ma, mb;
`ifdef MUL_ADD_SIGNED_EN
        ma = a[15] ? (32'd65536 - 32'(a)) : 32'(a);
        mb = b[15] ? (32'd65536 - 32'(b)) : 32'(b);
`else
        ma = 32'(a);
        mb = 32'(b);
`endif
        return (ma < mb) ? ma : mb;
    endfunction

    function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
`ifdef MUL_ADD_SIGNED_EN
        int sa, sb_v;
        sa   = int'($signed(a));
        sb_v = int'($signed(b));
        return 32'(sa * sb_v);
`else
        return 32'(a) * 32'(b);
`endif
    endfunction

    // cycle k (k=1 right after the accepting edge) is observed at t - t0 == k
    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.prod = model_prod(a, b);
        e.lat  = model_n(a, b) + 2;
        sb.push_back(e);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        t0    = t;
        tick();
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        sb.delete();
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++;
        if (product !== 32'd0) begin n_bad++; $display("FAIL reset_product got=%0d want=0", product); end
    endtask

    task automatic test_basic();
        exp_t e;
        bit   seen;
        accept(16'd69, 16'd9);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_c1 got=%b want=1", busy); end
        wait_done(40, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL basic_done_timeout got=none want=cycle %0d", e.lat); end
        n_cmp++;
        if (t - t0 !== e.lat) begin n_bad++; $display("FAIL basic_latency got=%0d want=%0d", t - t0, e.lat); end
        n_cmp++;
        if (product !== e.prod) begin n_bad++; $display("FAIL basic_product got=%0d want=%0d", product, e.prod); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done got=%b want=1", busy); end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_after_done got=done%b busy%b want=done0 busy0", done, busy);
        end
        n_cmp++;
        if (product !== 32'd621) begin n_bad++; $display("FAIL basic_hold got=%0d want=621", product); end
    endtask

    task automatic test_zero();
        exp_t        e;
        bit          seen;
        logic [15:0] av[2] = '{16'd0, 16'd500};
        logic [15:0] bv[2] = '{16'd500, 16'd0};
        for (int i = 0; i < 2; i++) begin
            accept(av[i], bv[i]);
            n_cmp++;
            if (product !== 32'd0) begin n_bad++; $display("FAIL zero_clear_%0d got=%0d want=0", i, product); end
            wait_done(10, seen);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || t - t0 !== e.lat) begin
                n_bad++; $display("FAIL zero_latency_%0d got=%0d seen=%b want=%0d", i, t - t0, seen, e.lat);
            end
            n_cmp++;
            if (product !== e.prod) begin n_bad++; $display("FAIL zero_product_%0d got=%0d want=%0d", i, product, e.prod); end
            tick();
        end
    endtask

    task automatic test_swap();
        exp_t e;
        bit   seen;
        bit   extra;
        accept(16'd3, 16'd40000);
        tick();
        start = 1'b1;
        a_in  = 16'd7;
        b_in  = 16'd7;
        tick();
        start = 1'b0;
        wait_done(20, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || t - t0 !== e.lat) begin
            n_bad++; $display("FAIL swap_latency got=%0d seen=%b want=%0d", t - t0, seen, e.lat);
        end
        n_cmp++;
        if (product !== e.prod) begin n_bad++; $display("FAIL swap_product got=%0d want=%0d", product, e.prod); end
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin n_bad++; $display("FAIL swap_start_queued got=activity want=idle"); end
    endtask

`ifdef MUL_ADD_SIGNED_EN
    task automatic test_signed();
        exp_t        e;
        bit          seen;
        logic [15:0] av[3] = '{16'hFFF9, 16'h8000, 16'hFFFB};
        logic [15:0] bv[3] = '{16'd6, 16'd2, 16'hFFFB};
        logic [31:0] pv[3] = '{32'hFFFF_FFD6, 32'hFFFF_0000, 32'd25};
        for (int i = 0; i < 3; i++) begin
            accept(av[i], bv[i]);
            wait_done(40, seen);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || t - t0 !== e.lat) begin
                n_bad++; $display("FAIL signed_latency_%0d got=%0d seen=%b want=%0d", i, t - t0, seen, e.lat);
            end
            n_cmp++;
            if (product !== e.prod || product !== pv[i]) begin
                n_bad++; $display("FAIL signed_product_%0d got=%h want=%h", i, product, pv[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        exp_t e;
        bit   seen;
        accept(16'd100, 16'd100);
        while (t - t0 < 50) tick();
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 16'd9;
        b_in  = 16'd9;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        void'(sb.pop_front());
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
            n_bad++; $display("FAIL reset_mid got=busy%b done%b prod%0d want=busy0 done0 prod0", busy, done, product);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_start_ignored got=%b want=0", busy); end
        accept(16'd2, 16'd3);
        wait_done(20, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || t - t0 !== 4) begin
            n_bad++; $display("FAIL reset_mid_restart_latency got=%0d seen=%b want=4", t - t0, seen);
        end
        n_cmp++;
        if (product !== e.prod) begin n_bad++; $display("FAIL reset_mid_restart_product got=%0d want=%0d", product, e.prod); end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t        e, got;
        logic        exp_done, exp_busy;
        logic [31:0] exp_prod;
        e.prod = model_prod(16'd5, 16'd3);
        e.lat  = model_n(16'd5, 16'd3) + 2;
        start = 1'b1;
        a_in  = 16'd5;
        b_in  = 16'd3;
        sb.push_back(e);
        t0 = t;
        for (int unsigned k = 1; k <= 18; k++) begin
            tick();
            exp_done = (k % 6 == 5);
            exp_busy = (k % 6 != 0);
            exp_prod = (k % 6 == 5 || k % 6 == 0) ? 32'd15 : 32'd0;
            n_cmp++;
            if (done !== exp_done) begin n_bad++; $display("FAIL b2b_done_c%0d got=%b want=%b", k, done, exp_done); end
            n_cmp++;
            if (busy !== exp_busy) begin n_bad++; $display("FAIL b2b_busy_c%0d got=%b want=%b", k, busy, exp_busy); end
            n_cmp++;
            if (product !== exp_prod) begin n_bad++; $display("FAIL b2b_product_c%0d got=%0d want=%0d", k, product, exp_prod); end
            if (done === 1'b1 && sb.size() != 0) begin
                got = sb.pop_front();
                n_cmp++;
                if (product !== got.prod) begin n_bad++; $display("FAIL b2b_sb_c%0d got=%0d want=%0d", k, product, got.prod); end
            end
            if (k == 6 || k == 12) sb.push_back(e);
        end
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0 || product !== 32'd15) begin
            n_bad++; $display("FAIL b2b_hold got=busy%b prod%0d want=busy0 prod15", busy, product);
        end
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_outstanding got=%0d want=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_swap();
`ifdef MUL_ADD_SIGNED_EN
        test_signed();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_add_seq.md
# mul_add_seq

Parametrised sequential multiplier that forms a product by repeated addition, with a controlling FSM and a datapath. It generalises the team's fixed 16-bit add-and-decrement multiplier in four ways: operand width is a parameter, both operands are captured in one cycle, the smaller operand is used as the loop counter, and completion is signalled with a start/busy/done handshake. It sits as a slave arithmetic unit behind any sequencer that can pulse `start` and wait for `done`.

## Interface
- `WIDTH`, default 16 — operand width in bits; must be at least 2.
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `start` input 1 — request a multiply; only accepted in IDLE.
- `a_in` input WIDTH — operand A; sampled on the accepting edge.
- `b_in` input WIDTH — operand B; sampled on the accepting edge.
- `busy` output 1 — high in LOAD-accepted states CALC and DONE.
- `done` output 1 — one-cycle pulse; `product` is valid while it is high.
- `product` output 2*WIDTH — result register; held until the next accepted `start`.

## Operation
- States are IDLE, CALC and DONE. Reset forces IDLE with `busy`=0, `done`=0, `product`=0, and all internal registers at 0.
- **IDLE.** When `start`=1 at the clock edge:
  - Load the accumulator with 0.
  - Load the addend register with max(|a|,|b|) and the counter register with min(|a|,|b|).
  - Latch the sign flag.
  - Clear `product`.
  - Go to CALC.
- **Magnitudes.** In unsigned mode, |x| is x and the sign flag is 0.
- **Ties.** When the magnitudes are equal, A is the addend.
- **CALC.**
  - If the counter is non-zero: accumulator <= accumulator + addend, counter <= counter − 1, stay in CALC.
  - If the counter is zero: `product` <= sign ? −accumulator : accumulator, truncated to 2*WIDTH bits. Go to DONE.
- **DONE.** `done`=1 for exactly this cycle, then go to IDLE.
- **Widths.**
  - The accumulator is 2*WIDTH bits and never overflows.
  - The addend and counter registers are WIDTH bits, unsigned.
- **`start` outside IDLE** (in CALC or DONE) is ignored. It is not queued.
- **Operand changes** after the accepting edge have no effect.
- **Zero operand.** The counter is 0, so CALC runs for one cycle and `product`=0.
- **Reset mid-operation.** Asserting `rst` in any state aborts the operation on that edge and restores the reset values, including `product`=0. A `start` in the same cycle as `rst` is ignored.

## Timing
- Let n = min(|a|,|b|). The accepting edge is cycle 0.
- CALC occupies cycles 1 to n+1: n additions plus one zero-check cycle.
- DONE, and therefore `done`=1, occurs in cycle n+2. The next `start` can be accepted in cycle n+3.
- `busy` rises in cycle 1 and falls in cycle n+3.
- Worst case is n = 2^(WIDTH−1) when signed and 2^WIDTH − 1 when unsigned.
- `product` changes only at the CALC→DONE edge and at the accepting edge (where it is cleared).
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Controlled by the macro `MUL_ADD_SIGNED_EN`.
- **Defined:** `a_in`, `b_in` and `product` are two's complement.
  - Magnitudes are taken at load time; −2^(WIDTH−1) maps to magnitude 2^(WIDTH−1) in the unsigned WIDTH-bit register.
  - The sign flag is a[WIDTH−1] ^ b[WIDTH−1].
  - The result is negated at the CALC→DONE edge when the sign flag is 1.
- **Undefined:** operands are unsigned and there is no negation logic.

## Structure
- Package `mul_add_pkg` holds:
  - the state enum (IDLE, CALC, DONE);
  - the default WIDTH constant;
  - a function that returns the 2*WIDTH result width.
- The natural sub-module is `mul_add_ctrl`, the FSM. Its inputs are `start` and counter-zero; its outputs are the load, add, decrement and result-store controls plus `busy` and `done`.
- The top level holds the datapath registers: accumulator, addend, counter, sign and `product`.

## Test plan
- **Basic unsigned.** WIDTH=16, a=69, b=9 -> counter=9, `done` in cycle 11, `product`=621, `busy` high in cycles 1–11.
- **Zero operand.** a=0, b=500 -> `done` in cycle 2, `product`=0. Swapped (a=500, b=0) gives the same result.
- **Operand swap.** a=3, b=40000 -> `done` in cycle 5, `product`=120000. A `start` pulse with new operands in cycle 2 is ignored and does not change the result.
- **Signed.** With `MUL_ADD_SIGNED_EN`: a=−7, b=6 -> `product`=−42 (0xFFFF_FFD6), `done` in cycle 8. Also a=−32768, b=2 -> `product`=−65536.
- **Reset mid-operation.** a=100, b=100; `rst` in cycle 50 -> in cycle 51 `busy`=0, `product`=0, no `done`. A new start with a=2, b=3 then gives `product`=6 in cycle 4 after acceptance.
- **Back-to-back.** Assert `start` held high continuously -> a new operation is accepted every n+3 cycles, `done` is exactly one cycle wide each time, and `product` holds between pulses.
